// File: rtl/vga_scan_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : vga_scan_controller_if                                      |
// | Purpose : Bundles the pixel enable, renderer coordinate/colour        |
// |           exchange and the VGA pin outputs of the scan controller.   |
// | Signals : pix_en            pixel-rate clock enable                   |
// |           x, y              scan coordinates to the renderer (11 b)   |
// |           r_in,g_in,b_in    renderer colour reply (3 b each)          |
// |           r, g, b           registered colour to the DAC (3 b each)   |
// |           hsync, vsync      active-low sync pins                      |
// |           active            visible-pixel flag aligned with r/g/b     |
// |           frame_start       one-clk pulse at the start of each frame  |
// | Modports: master = scan controller, slave = renderer/DAC side         |
// | Revision: 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface vga_scan_controller_if;
  logic        pix_en;
  logic [10:0] x;
  logic [10:0] y;
  logic [2:0]  r_in;
  logic [2:0]  g_in;
  logic [2:0]  b_in;
  logic [2:0]  r;
  logic [2:0]  g;
  logic [2:0]  b;
  logic        hsync;
  logic        vsync;
  logic        active;
  logic        frame_start;

  modport master (
    input  pix_en, r_in, g_in, b_in,
    output x, y, r, g, b, hsync, vsync, active, frame_start
  );

  modport slave (
    output pix_en, r_in, g_in, b_in,
    input  x, y, r, g, b, hsync, vsync, active, frame_start
  );
endinterface
`default_nettype wire

// File: rtl/vga_scan_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : vga_scan_controller                                         |
// | Purpose : 640x480@60 VGA timing generator. Presents x/y to a          |
// |           combinational renderer, registers its colour together with  |
// |           the sync/blank decode so every pin shares one step of delay.|
// | Ports   : clk   system clock                                          |
// |           rst   synchronous reset, active-low                         |
// |           bus   vga_scan_controller_if.master (pix_en, x/y, colour   |
// |                 in/out, hsync, vsync, active, frame_start)            |
// | Revision: 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module vga_scan_controller #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic                         clk,
  input  logic                         rst,
  vga_scan_controller_if.master        bus
);

  localparam logic [10:0] c_h_act      = 11'(H_ACTIVE);
  localparam logic [10:0] c_h_hs_start = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] c_h_hs_end   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] c_h_last     = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] c_v_act      = 11'(V_ACTIVE);
  localparam logic [10:0] c_v_vs_start = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] c_v_vs_end   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] c_v_last     = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [10:0] r_x;
  logic [10:0] r_y;
  logic [2:0]  r_red;
  logic [2:0]  r_grn;
  logic [2:0]  r_blu;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_active;
  logic        r_frame_start;

  logic        w_x_last;
  logic        w_y_last;
  logic        w_vis;
  logic        w_hs_n;
  logic        w_vs_n;

  // Decode is taken from the coordinate currently presented to the
  // renderer, so the registered sync/blank line up with the registered
  // colour of that same coordinate.
  assign w_x_last = (r_x == c_h_last);
  assign w_y_last = (r_y == c_v_last);
  assign w_vis    = (r_x < c_h_act) && (r_y < c_v_act);
  assign w_hs_n   = !((r_x >= c_h_hs_start) && (r_x < c_h_hs_end));
  assign w_vs_n   = !((r_y >= c_v_vs_start) && (r_y < c_v_vs_end));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_x           <= 11'd0;
      r_y           <= 11'd0;
      r_red         <= 3'd0;
      r_grn         <= 3'd0;
      r_blu         <= 3'd0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_active      <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      // Pulse defaults low every clk so it is one clk wide even when the
      // following cycles have pix_en low.
      r_frame_start <= 1'b0;
      if (bus.pix_en) begin
        if (w_x_last) begin
          r_x <= 11'd0;
          r_y <= w_y_last ? 11'd0 : r_y + 11'd1;
        end else begin
          r_x <= r_x + 11'd1;
        end
        r_active      <= w_vis;
        r_hsync       <= w_hs_n;
        r_vsync       <= w_vs_n;
        r_red         <= w_vis ? bus.r_in : 3'd0;
        r_grn         <= w_vis ? bus.g_in : 3'd0;
        r_blu         <= w_vis ? bus.b_in : 3'd0;
        r_frame_start <= w_x_last && w_y_last;
      end
    end
  end

  assign bus.x           = r_x;
  assign bus.y           = r_y;
  assign bus.r           = r_red;
  assign bus.g           = r_grn;
  assign bus.b           = r_blu;
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.active      = r_active;
  assign bus.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_vga_scan_controller                                      |
// | Purpose : Directed self-checking bench. u_dut uses default timing;    |
// |           u_dut_s keeps the default line but a 13-line frame         |
// |           (V 6/2/2/3) so full-frame behaviour fits a short run.      |
// | Revision: 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_vga_scan_controller;

  logic clk;
  logic rst;
  logic pix_en;
  logic rmode;

  int n_cmp;
  int n_bad;

  vga_scan_controller_if bus_d ();
  vga_scan_controller_if bus_s ();

  vga_scan_controller u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_d)
  );

  vga_scan_controller #(
    .V_ACTIVE (6),
    .V_FP     (2),
    .V_SYNC   (2),
    .V_BP     (3)
  ) u_dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  // Renderer for the default DUT: constant 7/0/4, or a quadrant pattern.
  assign bus_d.pix_en = pix_en;
  assign bus_d.r_in   = !rmode ? 3'd7 : ((bus_d.x < 11'd320) ? 3'd7 : 3'd1);
  assign bus_d.g_in   = !rmode ? 3'd0 : ((bus_d.y < 11'd240) ? 3'd3 : 3'd5);
  assign bus_d.b_in   = !rmode ? 3'd4 : bus_d.x[2:0];

  assign bus_s.pix_en = pix_en;
  assign bus_s.r_in   = 3'd7;
  assign bus_s.g_in   = 3'd0;
  assign bus_s.b_in   = 3'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock; sampling and driving both happen 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_x(input int tx);
    for (int i = 0; i < 1000 && bus_d.x != 11'(tx); i++) step();
    check_val("reach_x", bus_d.x, tx);
  endtask

  int xp, yp, hs_low, act_cnt, col_err, first_low, steps;
  int vs_low, hs_low_s, act_s, fs_cnt, first_vs_y, x_hold;
  logic vis;

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst    = 1'b0;
    pix_en = 1'b1;
    rmode  = 1'b0;

    // Reset held for 3 clk with pix_en high.
    repeat (3) step();
    check_val("rst_x", bus_d.x, 0);
    check_val("rst_y", bus_d.y, 0);
    check_val("rst_rgb", {bus_d.r, bus_d.g, bus_d.b}, 0);
    check_val("rst_hsync", bus_d.hsync, 1);
    check_val("rst_vsync", bus_d.vsync, 1);
    check_val("rst_active", bus_d.active, 0);
    check_val("rst_frame_start", bus_d.frame_start, 0);

    // Release: first edge presents (0,0) and registers its colour.
    rst = 1'b1;
    step();
    check_val("rel_x", bus_d.x, 1);
    check_val("rel_active", bus_d.active, 1);
    check_val("rel_r", bus_d.r, 7);
    check_val("rel_g", bus_d.g, 0);
    check_val("rel_b", bus_d.b, 4);
    step();
    check_val("rel_x2", bus_d.x, 2);

    // Clock enable toggling: x advances only on enabled edges, outputs hold.
    pix_en = 1'b0;
    step();
    check_val("ce_hold_x", bus_d.x, 2);
    check_val("ce_hold_r", bus_d.r, 7);
    check_val("ce_hold_active", bus_d.active, 1);
    pix_en = 1'b1;
    step();
    check_val("ce_adv_x", bus_d.x, 3);
    pix_en = 1'b0;
    step();
    check_val("ce_hold_x2", bus_d.x, 3);
    pix_en = 1'b1;

    // Advance to start of line 1, then measure a whole line.
    for (int i = 0; i < 900 && bus_d.x != 11'd0; i++) step();
    check_val("line_wrap_y", bus_d.y, 1);
    hs_low = 0; act_cnt = 0; col_err = 0; first_low = -1;
    for (int i = 0; i < 800; i++) begin
      xp = int'(bus_d.x);
      yp = int'(bus_d.y);
      step();
      vis = (xp < 640) && (yp < 480);
      if (bus_d.hsync === 1'b0) begin
        hs_low++;
        if (first_low < 0) first_low = xp;
      end
      if (bus_d.active === 1'b1) act_cnt++;
      if (bus_d.active !== vis || bus_d.r !== (vis ? 3'd7 : 3'd0) ||
          bus_d.g !== 3'd0 || bus_d.b !== (vis ? 3'd4 : 3'd0))
        col_err++;
    end
    check_val("line_hsync_low", hs_low, 96);
    check_val("line_hsync_first_x", first_low, 656);
    check_val("line_active", act_cnt, 640);
    check_val("line_colour_err", col_err, 0);
    check_val("line_end_x", bus_d.x, 0);
    check_val("line_end_y", bus_d.y, 2);
    check_val("line_vsync", bus_d.vsync, 1);

    // Quadrant renderer: colour appears one step after the coordinate.
    rmode = 1'b1;
    run_to_x(100);
    step();
    check_val("quad_100_rgb", {bus_d.r, bus_d.g, bus_d.b}, {3'd7, 3'd3, 3'd4});
    run_to_x(403);
    step();
    check_val("quad_403_rgb", {bus_d.r, bus_d.g, bus_d.b}, {3'd1, 3'd3, 3'd3});
    run_to_x(700);
    step();
    check_val("blank_700_rgb", {bus_d.r, bus_d.g, bus_d.b}, 0);
    check_val("blank_700_active", bus_d.active, 0);
    check_val("blank_700_hsync", bus_d.hsync, 0);

    // Mid-line reset with pix_en low: reset must still win.
    rst    = 1'b0;
    pix_en = 1'b0;
    step();
    check_val("mid_rst_xy", {bus_d.x, bus_d.y}, 0);
    check_val("mid_rst_hsync", bus_d.hsync, 1);
    check_val("mid_rst_active", bus_d.active, 0);
    check_val("mid_rst_rgb", {bus_d.r, bus_d.g, bus_d.b}, 0);
    check_val("mid_rst_s_xy", {bus_s.x, bus_s.y}, 0);

    rst    = 1'b1;
    pix_en = 1'b1;
    step();
    check_val("resume_x", bus_d.x, 1);
    check_val("resume_y", bus_d.y, 0);
    check_val("resume_r", bus_d.r, 7);

    // Short-frame DUT: frame is 800*13 = 10400 steps after release.
    steps = 1;
    while (steps < 12000 && bus_s.frame_start !== 1'b1) begin
      step();
      steps++;
    end
    check_val("frame_start_period", steps, 10400);
    check_val("frame_wrap_xy", {bus_s.x, bus_s.y}, 0);
    check_val("dflt_no_frame_start", bus_d.frame_start, 0);

    // Pulse is one clk wide even though this cycle has pix_en low.
    x_hold = int'(bus_d.x);
    pix_en = 1'b0;
    step();
    check_val("frame_start_width", bus_s.frame_start, 0);
    check_val("ce_hold_x3", bus_d.x, x_hold);
    pix_en = 1'b1;

    vs_low = 0; hs_low_s = 0; act_s = 0; fs_cnt = 0; first_vs_y = -1;
    for (int i = 0; i < 10400; i++) begin
      yp = int'(bus_s.y);
      step();
      if (bus_s.vsync === 1'b0) begin
        vs_low++;
        if (first_vs_y < 0) first_vs_y = yp;
      end
      if (bus_s.hsync === 1'b0) hs_low_s++;
      if (bus_s.active === 1'b1) act_s++;
      if (bus_s.frame_start === 1'b1) fs_cnt++;
    end
    check_val("frame_vsync_low", vs_low, 1600);
    check_val("frame_vsync_first_y", first_vs_y, 8);
    check_val("frame_hsync_low", hs_low_s, 1248);
    check_val("frame_active", act_s, 3840);
    check_val("frame_start_count", fs_cnt, 1);
    check_val("frame_start_last", bus_s.frame_start, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_scan_controller.md
Name: vga_scan_controller

Overview:
- Generates 640x480@60 Hz VGA timing and sequences the pixel renderer.
- Drives the x/y scan coordinates to the combinational renderer and samples its 3-bit-per-channel colour reply.
- Delays the sync and blank signals so they stay aligned with the registered colour, then drives the VGA pins.
- Sits between the board clock/clock-enable logic and the DAC/VGA connector.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels); line total 800
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines); frame total 525

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- pix_en  in  1  pixel-rate clock enable (e.g. every 2nd clk at 50 MHz)
- x  out  11  current horizontal scan count to renderer; register
- y  out  11  current vertical scan count to renderer; register
- r_in  in  3  renderer red for (x,y)
- g_in  in  3  renderer green
- b_in  in  3  renderer blue
- r  out  3  registered red to DAC
- g  out  3  registered green to DAC
- b  out  3  registered blue to DAC
- hsync  out  1  horizontal sync, active-low, registered
- vsync  out  1  vertical sync, active-low, registered
- active  out  1  high when r/g/b carry a visible pixel, registered
- frame_start  out  1  one-clk pulse at the start of each frame

Behaviour:
- All state updates on posedge clk only.
- rst=0 at any edge forces the reset state, overriding pix_en:
  - x=0, y=0
  - r=g=b=0
  - hsync=1, vsync=1
  - active=0, frame_start=0
- Reset mid-frame restarts the scan at (0,0). There is no partial-line recovery.
- Counters advance only on edges with pix_en=1. With pix_en=0, x, y, r, g, b, hsync, vsync and active hold.
- Horizontal counter:
  - x counts 0..H_TOTAL-1 (799).
  - At 799, x wraps to 0 and y increments.
- Vertical counter:
  - y counts 0..V_TOTAL-1 (524).
  - At x=799 and y=524, both wrap to 0.
- Decode, from the current x/y (pre-register):
  - vis = (x<H_ACTIVE) && (y<V_ACTIVE)
  - hs_n = 0 iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, i.e. x in [656,751]
  - vs_n = 0 iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, i.e. y in [490,491]
- Output register, on each pix_en edge:
  - active <= vis
  - hsync <= hs_n
  - vsync <= vs_n
  - r/g/b <= vis ? r_in/g_in/b_in : 0
- Latency:
  - Colour for coordinate (x,y) appears on r/g/b one pix_en step after (x,y) is presented.
  - hsync, vsync and active carry the same one-step delay, so all pins stay mutually aligned.
- r_in/g_in/b_in must be a combinational function of x/y. They are sampled in the same clk cycle as the pix_en edge.
- Blanking: r/g/b are forced to 0 whenever vis=0, regardless of the renderer output.
- frame_start:
  - Set to 1 for exactly one clk cycle following the pix_en edge on which x=799, y=524 wrap to (0,0).
  - 0 otherwise, including cycles where pix_en=0.
- Widths: 11-bit counters. Compare constants are derived from parameters. No overflow is possible for the defaults (max 799).
- Synthesis constraint: H_ACTIVE+H_FP+H_SYNC+H_BP <= 2047, and the same for V.

Test Plan:
- Reset and hold: rst=0 for 3 clk with pix_en=1 -> x=0, y=0, rgb=0, hsync=1, vsync=1, active=0, frame_start=0. Release rst -> x increments by 1 per pix_en edge.
- Clock enable: pix_en toggles 1,0,1,0 -> x advances once per two clk. All outputs hold during pix_en=0 cycles.
- Line timing: run one line with pix_en=1 constantly ->
  - hsync low for exactly 96 pix_en steps, first low output one step after x=656.
  - active high for exactly 640 steps per visible line.
  - x wraps 799->0 and y increments.
- Frame timing: run a full frame ->
  - vsync low on lines 490-491 only (1600 pixel steps).
  - frame_start pulses once per 420000 pixel steps, one clk wide.
- Colour alignment and blanking: drive r_in=7, g_in=0, b_in=4 constant ->
  - r=7, b=4 exactly on the 640x480 active outputs.
  - r=g=b=0 at x=640..799 and y=480..524 (delayed one step).
  - Renderer quadrant stimulus, e.g. (x=100, y=100) -> red 7 appears one step later.
- Reset mid-frame: assert rst at x=300, y=200 for 1 clk -> next state x=0, y=0, outputs at reset values. Scan resumes from origin and the first frame_start occurs 420000 steps later.
